// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: received data plus status pulses.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;

  modport master (output rx_data, rx_valid, rx_busy, frame_err);
  modport slave  (input  rx_data, rx_valid, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first,
// single stop bit with framing-error and line-break handling.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to start-bit centre, rejecting glitches
// DATA  | sampling data bits at bit centres
// STOP  | sampling stop bit; deliver byte or flag framing error
// BREAK | stop bit was low; wait for line to return high
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        rx,
  uart_rx_if.master   rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e                 state_q,     state_d;
  logic                   sync1_q;
  logic                   rx_s_q;
  logic [CW-1:0]          tick_cnt_q,  tick_cnt_d;
  logic [BW-1:0]          bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
  logic                   rx_valid_q,  rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_TICK) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            shift_d[bit_idx_q] = rx_s_q;
            tick_cnt_d         = '0;
            if (bit_idx_q == LAST_BIT) state_d = STOP;
            else                       bit_idx_d = bit_idx_q + BW'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      BREAK: begin
        // one frame_err per break: wait here until the line is released
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected events into a queue,
// an independent monitor pops and compares on every rx_valid / frame_err pulse.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int FRAME_TICKS = OS / 2 + (DB + 1) * OS;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic tick;
  logic rx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_period = 1;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int valid_cyc[$];
  exp_t exp_q[$];

  uart_rx_if #(.DATA_BITS(DB)) u_if ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .rx    (rx),
    .rx_if (u_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_period <= 1) tick = 1'b1;
      else begin
        tick = (tcnt == 0);
        tcnt = (tcnt + 1) % tick_period;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic prev_v, prev_e;
    exp_t e;
    prev_v = 1'b0;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.rx_valid && u_if.frame_err) begin
        checks++; errors++;
        $display("FAIL both_pulses: rx_valid and frame_err high together at cyc %0d", cyc);
      end
      if ((u_if.rx_valid && prev_v) || (u_if.frame_err && prev_e)) begin
        checks++; errors++;
        $display("FAIL pulse_width: valid=%0b err=%0b held >1 clk at cyc %0d", u_if.rx_valid, u_if.frame_err, cyc);
      end
      if ((u_if.rx_valid && !prev_v) || (u_if.frame_err && !prev_e)) begin
        if (u_if.rx_valid) begin valid_cnt++; valid_cyc.push_back(cyc); end
        if (u_if.frame_err) ferr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid=%0b err=%0b data=%02h, nothing expected", u_if.rx_valid, u_if.frame_err, u_if.rx_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err != u_if.frame_err || u_if.rx_data !== e.data) begin
            errors++;
            $display("FAIL sb_event: got err=%0b data=%02h, expected err=%0b data=%02h", u_if.frame_err, u_if.rx_data, e.is_err, e.data);
          end
        end
      end
      prev_v = u_if.rx_valid;
      prev_e = u_if.frame_err;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bclk);
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (bclk) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic wait_valid(input int n, input int budget);
    int k;
    k = 0;
    while (valid_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (valid_cnt < n) begin
      errors++;
      $display("FAIL wait_valid: got %0d pulses, expected %0d within %0d clk", valid_cnt, n, budget);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"},   int'(u_if.rx_data),   0);
    check({tag, "_rx_valid"},  int'(u_if.rx_valid),  0);
    check({tag, "_rx_busy"},   int'(u_if.rx_busy),   0);
    check({tag, "_frame_err"}, int'(u_if.frame_err), 0);
  endtask

  initial begin
    int start_cyc;
    int busy_cnt;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2 * OS) @(negedge clk);

    // 0xA5, tick every clk: stop-bit decision 3 + FRAME_TICKS clk after start edge
    exp_q.push_back('{1'b0, 8'hA5});
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, OS);
    wait_valid(1, 4 * OS);
    if (valid_cyc.size() >= 1) check("a5_latency", valid_cyc[0] - start_cyc, 3 + FRAME_TICKS);
    check("a5_rx_data", int'(u_if.rx_data), 8'hA5);
    repeat (2 * OS) @(negedge clk);

    // back-to-back 0x00, 0xFF
    exp_q.push_back('{1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'hFF});
    send_frame(8'h00, 1'b1, OS);
    send_frame(8'hFF, 1'b1, OS);
    wait_valid(3, 4 * OS);
    if (valid_cyc.size() >= 3) check("b2b_spacing", valid_cyc[2] - valid_cyc[1], 10 * OS);
    repeat (2 * OS) @(negedge clk);

    // 4-tick glitch: busy only for the half-bit qualification window
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 3 * OS; i++) begin
      @(negedge clk);
      if (i == 3) rx = 1'b1;
      if (u_if.rx_busy) busy_cnt++;
    end
    check("glitch_busy_clks", busy_cnt, OS / 2);
    check("glitch_no_valid", valid_cnt, 3);
    check("glitch_no_ferr", ferr_cnt, 0);

    // 0x3C with low stop bit, then held low for 30 bit periods
    exp_q.push_back('{1'b1, 8'hFF});
    send_frame(8'h3C, 1'b0, OS);
    repeat (30 * OS) @(negedge clk);
    check("break_busy_held", int'(u_if.rx_busy), 1);
    check("break_rx_data_kept", int'(u_if.rx_data), 8'hFF);
    check("break_one_ferr", ferr_cnt, 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_released", int'(u_if.rx_busy), 0);
    repeat (2 * OS) @(negedge clk);

    // reset during bit 4 of 0x5A, then clean 0x81
    rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 1 || i == 3);
      repeat (OS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (OS / 2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("midreset");
    reset = 1'b1;
    repeat (2 * OS) @(negedge clk);
    exp_q.push_back('{1'b0, 8'h81});
    send_frame(8'h81, 1'b1, OS);
    wait_valid(4, 4 * OS);
    check("post_reset_rx_data", int'(u_if.rx_data), 8'h81);
    repeat (2 * OS) @(negedge clk);

    // tick once every 7 clk, 0xC3
    tick_period = 7;
    repeat (3 * 7 * OS) @(negedge clk);
    exp_q.push_back('{1'b0, 8'hC3});
    start_cyc = cyc;
    send_frame(8'hC3, 1'b1, 7 * OS);
    wait_valid(5, 4 * 7 * OS);
    if (valid_cyc.size() >= 5)
      check_range("slow_tick_latency", valid_cyc[4] - start_cyc,
                  3 + 1 + (FRAME_TICKS - 1) * 7, 3 + 7 + (FRAME_TICKS - 1) * 7);
    check("slow_tick_rx_data", int'(u_if.rx_data), 8'hC3);
    repeat (2 * OS) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
